// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the iterative MUL AB / DIV AB unit.
// SFR addresses, operation codes and FSM state encodings.
package muldiv_seq_pkg;

    localparam logic [7:0] SFR_ACC = 8'hE0;
    localparam logic [7:0] SFR_B   = 8'hF0;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CALC   = 3'd1;
    localparam logic [2:0] ST_WR_ACC = 3'd2;
    localparam logic [2:0] ST_WR_B   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CALC   = ST_CALC,
        WR_ACC = ST_WR_ACC,
        WR_B   = ST_WR_B,
        DONE   = ST_DONE
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide.
// Register layout: [15:8] = high byte / remainder, [7:0] = multiplier / quotient.
module muldiv_step
    import muldiv_seq_pkg::*;
(
    input  logic        op,
    input  logic [15:0] prod_i,
    input  logic [7:0]  opnd_i,
    output logic [15:0] prod_o
);

    logic [8:0] sum;
    logic [8:0] shl;
    logic [9:0] diff;
    logic       no_borrow;

    // Compute both candidate iterations and select by operation
    always_comb begin
        sum       = {1'b0, prod_i[15:8]} + (prod_i[0] ? {1'b0, opnd_i} : 9'd0);
        shl       = {prod_i[15:8], prod_i[7]};
        diff      = {1'b0, shl} - {2'b00, opnd_i};
        // Remainder stays below the divisor, so a valid difference fits in 8 bits
        no_borrow = (diff[9:8] == 2'b00);
        if (op == OP_DIV) begin
            prod_o = {(no_borrow ? diff[7:0] : shl[7:0]), prod_i[6:0], no_borrow};
        end else begin
            prod_o = {sum, prod_i[7:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative 8051 MUL AB / DIV AB unit.
// Computes in 8 cycles, writes ACC then B, then pulses done with OV/CY.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       op,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] sfr_data,
    output logic [7:0] sfr_addr,
    output logic       sfr_wr_en,
    output logic       sfr_wr_bit_en,
    output logic       bit_out,
    output logic       ov_out,
    output logic       cy_out
);

    state_e      state_q, state_d;
    logic        op_q, op_d;
    logic [7:0]  opnd_q, opnd_d;
    logic [15:0] prod_q, prod_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  addr_q, addr_d;
    logic        wr_q, wr_d;
    logic        ov_q, ov_d;
    logic [15:0] step_out;

    muldiv_step u_step (
        .op     (op_q),
        .prod_i (prod_q),
        .opnd_i (opnd_q),
        .prod_o (step_out)
    );

    // Next state plus registered outputs for the state being entered
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        data_d  = 8'h00;
        addr_d  = 8'h00;
        wr_d    = 1'b0;
        ov_d    = ov_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = op;
                    opnd_d = b_in;
                    prod_d = {8'h00, a_in};
                    cnt_d  = 4'd0;
                    if (op == OP_DIV && b_in == 8'h00) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        ov_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                prod_d = step_out;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d = WR_ACC;
                    wr_d    = 1'b1;
                    addr_d  = SFR_ACC;
                    data_d  = step_out[7:0];
                end
            end
            WR_ACC: begin
                state_d = WR_B;
                wr_d    = 1'b1;
                addr_d  = SFR_B;
                data_d  = prod_q[15:8];
            end
            WR_B: begin
                state_d = DONE;
                done_d  = 1'b1;
                ov_d    = (op_q == OP_MUL) && (prod_q[15:8] != 8'h00);
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            opnd_q  <= 8'h00;
            prod_q  <= 16'h0000;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
            addr_q  <= 8'h00;
            wr_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            ov_q    <= ov_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign sfr_data      = data_q;
    assign sfr_addr      = addr_q;
    assign sfr_wr_en     = wr_q;
    assign sfr_wr_bit_en = 1'b0;
    assign bit_out       = 1'b0;
    assign ov_out        = ov_q;
    assign cy_out        = 1'b0;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative MUL AB / DIV AB execution unit. Sits directly upstream of the accumulator and B SFRs.
- Drives the SFR write bus (data, address, write enable, bit-write enable) that the ACC and B registers consume.
- Sequences one result write to ACC, then one to B.
- Reports OV/CY to the PSW logic with a one-cycle done pulse.

Parameters:
- None. Datapath is fixed at 8 bits (8051).
- SFR_ACC (8'hE0) and SFR_B (8'hF0) come from define_opcodes.v.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  1  0 = MUL AB, 1 = DIV AB
- a_in  input  8  current ACC value
- b_in  input  8  current B value
- busy  output  1  high from the cycle after start is accepted until DONE (inclusive)
- done  output  1  one-cycle pulse; ov_out/cy_out valid and PSW update strobe
- sfr_data  output  8  SFR write data
- sfr_addr  output  8  SFR write address
- sfr_wr_en  output  1  SFR byte write strobe
- sfr_wr_bit_en  output  1  constant 0 (byte writes only)
- bit_out  output  1  constant 0
- ov_out  output  1  overflow flag result
- cy_out  output  1  carry flag result (always 0)

Behaviour:
- Clock/reset: one clock. reset is asynchronous, active-high; it forces all state and outputs to 0 and FSM to IDLE.
- Reset values: busy=0, done=0, sfr_data=0, sfr_addr=0, sfr_wr_en=0, ov_out=0, cy_out=0.
- FSM states: IDLE, CALC, WR_ACC, WR_B, DONE.
- IDLE: on start=1, latch op/a_in/b_in and clear the 4-bit iteration counter.
  - DIV with b_in==0 goes to DONE.
  - Otherwise goes to CALC.
- CALC: exactly 8 cycles (counter 0..7); one iteration per cycle; then WR_ACC.
- MUL: shift-add over a 16-bit product register.
  - Result: low byte -> ACC, high byte -> B.
  - OV = (high byte != 0).
- DIV: restoring shift-subtract.
  - 9-bit partial remainder; quotient bit = no-borrow.
  - Result: quotient -> ACC, remainder -> B. OV = 0.
- WR_ACC: one cycle; sfr_wr_en=1, sfr_addr=SFR_ACC, sfr_data = ACC result.
- WR_B: one cycle; sfr_wr_en=1, sfr_addr=SFR_B, sfr_data = B result.
- DONE: one cycle; done=1; ov_out/cy_out updated; next state IDLE.
- Timing (start sampled at edge 0):
  - CALC: cycles 1-8.
  - WR_ACC: cycle 9.
  - WR_B: cycle 10.
  - DONE: cycle 11.
  - Next start accepted at cycle 12.
- Divide by zero: DONE at cycle 1, no SFR writes (ACC/B unchanged), ov_out=1, cy_out=0.
- cy_out is always 0. ov_out/cy_out hold their value until the next DONE.
- sfr_wr_en is low in every state except WR_ACC/WR_B. sfr_data/sfr_addr return to 0 outside those states.
- start while busy is ignored (no queueing). Operands changing after acceptance have no effect.
- Reset during any state aborts the operation:
  - No further writes.
  - A write in progress on the same edge is suppressed, because reset is asynchronous.
- No combinational path from start/a_in/b_in to any output; all outputs are registered.

Decomposition:
- Shared constants:
  - SFR_ACC and SFR_B in define_opcodes.v.
  - Add localparams for the FSM state encodings (3 bits) and OP_MUL=0, OP_DIV=1 to define_opcodes.v.
- One natural sub-module: muldiv_step. Purely combinational single-iteration step (shift-add or shift-subtract), instantiated once.
- Counter and FSM live in muldiv_seq.

Test Plan:
- MUL 8'h50 x 8'hA0 -> product 16'h3200.
  - Cycle 9: write E0 <= 00. Cycle 10: write F0 <= 32.
  - Cycle 11: done, ov_out=1, cy_out=0.
- MUL 8'h0C x 8'h0A -> ACC<=8'h78, B<=8'h00, ov_out=0; busy high cycles 1-11.
- DIV 8'hFB / 8'h12 -> ACC<=8'h0D, B<=8'h11, ov_out=0, cy_out=0.
- DIV 8'h55 / 8'h00 -> no sfr_wr_en at any cycle; done at cycle 1; ov_out=1.
- MUL 8'h03 x 8'h04, then start pulsed at cycle 4 with op=DIV and different operands.
  - The second start is ignored; writes 8'h0C / 8'h00.
  - A new start at cycle 12 is accepted.
- Reset pulse at cycle 5 of a MUL FF x FF -> immediate IDLE.
  - busy=0, ov_out=0, no sfr_wr_en afterwards.
  - A following DIV 8'h64 / 8'h07 yields ACC 8'h0E, B 8'h02.
